// File: rtl/uart_imem_loader.sv
// UART receiver that loads DATA_W-bit words into a small instruction memory read by PC.
// Define UART_PARITY_EN to expect one even-parity bit after the data bits.
module uart_imem_loader #(
  parameter int CLK_DIV = 10416,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              RX,
  input  logic              Load,
  input  logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              FE,
  output logic              OVF,
  output logic              PE
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int DCW   = $clog2(DATA_W + 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;
`endif

  state_e             state_q;
  logic               rxMeta_q, rxSync_q, load_q;
  logic [CNT_W-1:0]   bitCnt_q;
  logic [DCW-1:0]     dataCnt_q;
  logic [DATA_W-1:0]  shift_q;
  logic [ADDR_W:0]    count_q;
  logic               fe_q, ovf_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               loadRise, bitEnd, halfBit, full, frameBad, stopGood, wrEn;

`ifdef UART_PARITY_EN
  logic pe_q, parErr_q;
  assign frameBad = parErr_q;
  assign PE       = pe_q;
`else
  assign frameBad = 1'b0;
  assign PE       = 1'b0;
`endif

  assign loadRise = Load & ~load_q;
  assign bitEnd   = (bitCnt_q == CNT_W'(CLK_DIV - 1));
  assign halfBit  = (bitCnt_q == CNT_W'(CLK_DIV / 2 - 1));
  assign full     = (count_q == (ADDR_W + 1)'(DEPTH));
  // A Load edge or a dropped Load in the stop-sample cycle suppresses the write.
  assign stopGood = (state_q == STOP) && bitEnd && rxSync_q && Load && !loadRise && !frameBad;
  assign wrEn     = stopGood && !full;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rxMeta_q  <= 1'b1;
      rxSync_q  <= 1'b1;
      load_q    <= 1'b0;
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      dataCnt_q <= '0;
      shift_q   <= '0;
      count_q   <= '0;
      fe_q      <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef UART_PARITY_EN
      pe_q      <= 1'b0;
      parErr_q  <= 1'b0;
`endif
    end else begin
      rxMeta_q <= RX;
      rxSync_q <= rxMeta_q;
      load_q   <= Load;
      if (loadRise) begin
        state_q  <= IDLE;
        bitCnt_q <= '0;
        count_q  <= '0;
        fe_q     <= 1'b0;
        ovf_q    <= 1'b0;
`ifdef UART_PARITY_EN
        pe_q     <= 1'b0;
`endif
      end else if (!Load) begin
        state_q   <= IDLE;
        bitCnt_q  <= '0;
        dataCnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!rxSync_q) begin
              state_q   <= START;
              bitCnt_q  <= '0;
              dataCnt_q <= '0;
`ifdef UART_PARITY_EN
              parErr_q  <= 1'b0;
`endif
            end
          end
          START: begin
            if (halfBit) begin
              bitCnt_q <= '0;
              state_q  <= rxSync_q ? IDLE : DATA;
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end
          DATA: begin
            if (bitEnd) begin
              bitCnt_q <= '0;
              shift_q  <= {rxSync_q, shift_q[DATA_W-1:1]};
              if (dataCnt_q == DCW'(DATA_W - 1)) begin
                dataCnt_q <= '0;
`ifdef UART_PARITY_EN
                state_q   <= PARITY;
`else
                state_q   <= STOP;
`endif
              end else begin
                dataCnt_q <= dataCnt_q + 1'b1;
              end
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end
`ifdef UART_PARITY_EN
          PARITY: begin
            if (bitEnd) begin
              bitCnt_q <= '0;
              state_q  <= STOP;
              if (rxSync_q != ^shift_q) begin
                parErr_q <= 1'b1;
                pe_q     <= 1'b1;
              end
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end
`endif
          STOP: begin
            if (bitEnd) begin
              bitCnt_q <= '0;
              if (rxSync_q) begin
                state_q <= IDLE;
                if (wrEn) begin
                  count_q <= count_q + 1'b1;
                end else if (stopGood) begin
                  ovf_q <= 1'b1;
                end
              end else begin
                fe_q    <= 1'b1;
                state_q <= BREAK;
              end
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end
          BREAK: begin
            if (rxSync_q) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Memory clears on reset but survives new load sessions.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wrEn && count_q == (ADDR_W + 1)'(i)) mem_q[i] <= shift_q;
      end
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (PC == ADDR_W'(i)) data_out = mem_q[i];
    end
  end

  assign Count = count_q;
  assign Full  = full;
  assign FE    = fe_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: directed session scenarios plus random frames
// compared against a word-level model of the load session.
module tb_uart_imem_loader;

  localparam int CLK_DIV = 16;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 3;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              RX;
  logic              Load;
  logic [ADDR_W-1:0] PC;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W:0]   Count;
  logic              Full, FE, OVF, PE;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] memModel [DEPTH];
  int                countModel;
  bit                feModel, ovfModel, peModel;

  always #5 Clk = ~Clk;

  uart_imem_loader #(
    .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .RX(RX), .Load(Load), .PC(PC),
    .data_out(data_out), .Count(Count), .Full(Full), .FE(FE), .OVF(OVF), .PE(PE)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic sendBit(input logic b, input int bits);
    RX = b;
    waitCycles(CLK_DIV * bits);
  endtask

  // One UART frame; stopLowBits>0 holds the stop bit low, abortBit drops Load before that data bit.
  task automatic applyStimulus(input logic [7:0] d, input int stopLowBits, input int abortBit, input logic parBit);
    sendBit(1'b0, 1);
    for (int i = 0; i < DATA_W; i++) begin
      if (i == abortBit) Load = 1'b0;
      sendBit(d[i], 1);
    end
`ifdef UART_PARITY_EN
    sendBit(parBit, 1);
`else
    if (parBit === 1'bx) $display("[TB] note: parity bit undefined");
`endif
    if (stopLowBits > 0) sendBit(1'b0, stopLowBits);
    sendBit(1'b1, 1);
    waitCycles(4);
  endtask

  task automatic modelFrame(input logic [7:0] d, input bit stopBad, input bit parOk);
    if (!parOk) peModel = 1'b1;
    if (stopBad) feModel = 1'b1;
    else if (parOk) begin
      if (countModel < DEPTH) begin
        memModel[countModel] = d;
        countModel++;
      end else begin
        ovfModel = 1'b1;
      end
    end
  endtask

  task automatic sendGood(input logic [7:0] d);
    applyStimulus(d, 0, -1, ^d);
    modelFrame(d, 1'b0, 1'b1);
  endtask

  task automatic newSession();
    Load = 1'b0;
    waitCycles(3);
    Load = 1'b1;
    waitCycles(3);
    countModel = 0;
    feModel    = 1'b0;
    ovfModel   = 1'b0;
    peModel    = 1'b0;
  endtask

  task automatic checkAll(input string tag);
    logic [31:0] expWord;
    checkOutput({tag, ".Count"}, 32'(Count), 32'(countModel));
    checkOutput({tag, ".Full"},  32'(Full),  32'(countModel == DEPTH));
    checkOutput({tag, ".FE"},    32'(FE),    32'(feModel));
    checkOutput({tag, ".OVF"},   32'(OVF),   32'(ovfModel));
`ifdef UART_PARITY_EN
    checkOutput({tag, ".PE"},    32'(PE),    32'(peModel));
`else
    checkOutput({tag, ".PE"},    32'(PE),    32'd0);
`endif
    for (int p = 0; p < (1 << ADDR_W); p++) begin
      PC = ADDR_W'(p);
      #1;
      expWord = (p < DEPTH) ? 32'(memModel[p]) : 32'd0;
      checkOutput($sformatf("%s.mem%0d", tag, p), 32'(data_out), expWord);
    end
  endtask

  initial begin
    logic [7:0] d;
    bit         bad;
    Reset_n = 1'b0;
    Load    = 1'b1;
    RX      = 1'b1;
    PC      = '0;
    for (int i = 0; i < DEPTH; i++) memModel[i] = '0;
    countModel = 0; feModel = 0; ovfModel = 0; peModel = 0;
    waitCycles(3);
    checkOutput("inReset.data_out", 32'(data_out), 32'd0);
    checkOutput("inReset.Count", 32'(Count), 32'd0);
    Reset_n = 1'b1;
    waitCycles(3);
    checkAll("reset");

    newSession();
    sendGood(8'h45);
    sendGood(8'h35);
    sendGood(8'h00);
    checkAll("load3");

    newSession();
    for (int v = 8'h11; v <= 8'h16; v++) sendGood(8'(v));
    checkAll("overflow");

    newSession();
    applyStimulus(8'hA5, 3, -1, ^8'hA5);
    modelFrame(8'hA5, 1'b1, 1'b1);
    checkAll("break");
    sendGood(8'h5A);
    checkAll("afterBreak");

    newSession();
    RX = 1'b0;
    waitCycles(4);
    RX = 1'b1;
    waitCycles(2 * CLK_DIV);
    checkAll("glitch");
    applyStimulus(8'h3C, 0, 4, ^8'h3C);
    checkAll("abort");
    newSession();
    checkAll("reload");

`ifdef UART_PARITY_EN
    newSession();
    applyStimulus(8'h07, 0, -1, 1'b0);
    modelFrame(8'h07, 1'b0, 1'b0);
    checkAll("parityBad");
    applyStimulus(8'h07, 0, -1, 1'b1);
    modelFrame(8'h07, 1'b0, 1'b1);
    checkAll("parityGood");
`endif

    for (int r = 0; r < 2; r++) begin
      newSession();
      for (int k = 0; k < 7; k++) begin
        d   = 8'($urandom);
        bad = ($urandom_range(0, 3) == 0);
        applyStimulus(d, bad ? 1 : 0, -1, ^d);
        modelFrame(d, bad, 1'b1);
      end
      checkAll($sformatf("random%0d", r));
    end

    newSession();
    RX = 1'b0;
    waitCycles(3 * CLK_DIV);
    Reset_n = 1'b0;
    waitCycles(2);
    for (int i = 0; i < DEPTH; i++) memModel[i] = '0;
    countModel = 0; feModel = 0; ovfModel = 0; peModel = 0;
    checkAll("midReset");
    RX = 1'b1;
    waitCycles(2);
    Reset_n = 1'b1;
    waitCycles(12 * CLK_DIV);
    checkAll("postReset");
    sendGood(8'h99);
    checkAll("resume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
